// File: rtl/comm_pkg.sv
// Shared types and constants for the wireless command link: rx/tx state
// encodings, command opcodes and the positive acknowledge byte.
package comm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } rx_state_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_t;

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;

   localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/cmd_frame_rx_if.sv
// Bundle of the UART-facing and command-facing handshake signals of cmd_frame_rx.
// master = surrounding system (UART, command block), slave = cmd_frame_rx.
interface cmd_frame_rx_if;

   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rx_rdy;
   logic        cmd_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        clr_cmd_rdy;
   logic        snd_resp;
   logic [7:0]  resp;
   logic        trmt;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        frame_err;

   modport master (
      output rx_rdy, rx_data, clr_cmd_rdy, snd_resp, resp, tx_done,
      input  clr_rx_rdy, cmd_rdy, cmd, data, trmt, tx_data, frame_err
   );

   modport slave (
      input  rx_rdy, rx_data, clr_cmd_rdy, snd_resp, resp, tx_done,
      output clr_rx_rdy, cmd_rdy, cmd, data, trmt, tx_data, frame_err
   );

endinterface

// File: rtl/resp_tx_buf.sv
// Response transmit path: starts UART transmits of 1-byte responses and holds
// at most one pending byte while a transmit is in flight.
module resp_tx_buf
   import comm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       snd_resp,
   input  logic [7:0] resp,
   input  logic       tx_done,
   output logic       trmt,
   output logic [7:0] tx_data
);

   tx_state_t  state, state_nxt;
   logic       pend_valid;
   logic [7:0] pend_data;
   logic       done_busy;
   logic       free;
   logic       load_resp;
   logic       load_pend;
   logic       write_pend;

   // A tx_done with nothing pending frees the transmitter within the same
   // cycle, so a coincident snd_resp is sent straight away rather than parked.
   assign done_busy = (state == TX_BUSY) && tx_done;
   assign free      = (state == TX_IDLE) || (done_busy && !pend_valid);

   always_ff @(posedge clk) begin
      if (rst) state <= TX_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (free) state_nxt = snd_resp ? TX_BUSY : TX_IDLE;
   end

   always_comb begin
      load_resp  = snd_resp && free;
      load_pend  = done_busy && pend_valid;
      write_pend = snd_resp && !free;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trmt       <= 1'b0;
         tx_data    <= 8'h00;
         pend_valid <= 1'b0;
         pend_data  <= 8'h00;
      end else begin
         trmt <= load_resp || load_pend;
         if (load_resp)      tx_data <= resp;
         else if (load_pend) tx_data <= pend_data;
         if (write_pend) begin
            pend_data  <= resp;
            pend_valid <= 1'b1;
         end else if (load_pend) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cmd_frame_rx.sv
// Assembles 3-byte UART frames into cmd/data with a cmd_rdy handshake and
// queues response bytes to the UART transmitter. Optional inter-byte gap
// timeout is enabled by defining FRAME_TIMEOUT_EN.
module cmd_frame_rx
   import comm_pkg::*;
#(
   parameter int TIMEOUT_CYC = 2_500_000,
   parameter int TMR_W       = 22
) (
   input  logic           clk,
   input  logic           rst,
   cmd_frame_rx_if.slave  bus
);

   if (2**TMR_W <= TIMEOUT_CYC) begin : g_tmr_w_check
      $error("TMR_W too narrow to count TIMEOUT_CYC");
   end

   rx_state_t   state, state_nxt;
   logic        accept;
   logic        stage_op;
   logic        stage_hi;
   logic        frame_done;
   logic        timeout;
   logic        clr_rx_rdy_q;
   logic        cmd_rdy_q;
   logic        frame_err_q;
   logic [7:0]  op_q;
   logic [7:0]  hi_q;
   logic [7:0]  cmd_q;
   logic [15:0] data_q;
   logic        trmt;
   logic [7:0]  tx_data;

   // rx_rdy is a level held until the clear pulse lands; masking with our own
   // pending clear keeps one byte from being taken twice.
   assign accept = bus.rx_rdy && !clr_rx_rdy_q;

`ifdef FRAME_TIMEOUT_EN
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(TIMEOUT_CYC - 1);
   logic [TMR_W-1:0] gap_cnt;

   assign timeout = (state != IDLE) && !accept && (gap_cnt == GAP_LAST);

   always_ff @(posedge clk) begin
      if (rst || accept || state == IDLE) gap_cnt <= '0;
      else                                gap_cnt <= gap_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: registered state always uses non-blocking assignment.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first, so every path assigns state_nxt and no latch forms.
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = HIGH;
         HIGH:    if (accept) state_nxt = LOW;
                  else if (timeout) state_nxt = IDLE;
         LOW:     if (accept || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      stage_op   = 1'b0;
      stage_hi   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE:    stage_op   = accept;
         HIGH:    stage_hi   = accept;
         LOW:     frame_done = accept;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_rx_rdy_q <= 1'b0;
         cmd_rdy_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         op_q         <= 8'h00;
         hi_q         <= 8'h00;
         cmd_q        <= 8'h00;
         data_q       <= 16'h0000;
      end else begin
         clr_rx_rdy_q <= accept;
         frame_err_q  <= timeout;
         if (stage_op) op_q <= bus.rx_data;
         if (stage_hi) hi_q <= bus.rx_data;
         // cmd/data change only on the final byte so the consumer never sees
         // a half-updated frame while the next one is staging.
         if (frame_done) begin
            cmd_q  <= op_q;
            data_q <= {hi_q, bus.rx_data};
         end
         if (frame_done)                         cmd_rdy_q <= 1'b1;
         else if (bus.clr_cmd_rdy || stage_op)   cmd_rdy_q <= 1'b0;
      end
   end

   resp_tx_buf u_resp_tx_buf (
      .clk      (clk),
      .rst      (rst),
      .snd_resp (bus.snd_resp),
      .resp     (bus.resp),
      .tx_done  (bus.tx_done),
      .trmt     (trmt),
      .tx_data  (tx_data)
   );

   assign bus.clr_rx_rdy = clr_rx_rdy_q;
   assign bus.cmd_rdy    = cmd_rdy_q;
   assign bus.cmd        = cmd_q;
   assign bus.data       = data_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.trmt       = trmt;
   assign bus.tx_data    = tx_data;

endmodule
